// File: rtl/flash_read_pkg.sv
// Shared definitions for the NOR flash read front-end.
//   state_t      : controller states (idle, access wait, data capture)
//   FLASH_*_W    : flash data bus / word address widths
//   MISS_CNT_W   : width of the saturating flash-access counter
//   WAIT_CNT_W   : width of the access wait-state down-counter
package flash_read_pkg;

    localparam int FLASH_WORD_W = 16;
    localparam int FLASH_ADDR_W = 24;
    localparam int MISS_CNT_W   = 16;
    localparam int WAIT_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    function automatic logic [7:0] sel_byte(input logic [FLASH_WORD_W-1:0] word,
                                            input logic                    hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/flash_line_buffer.sv
// Single-entry line buffer holding the most recently fetched flash word.
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_lookup_tag / o_hit    word-address compare against the stored tag
//   i_inval                 clear the valid bit
//   i_fill_*                load tag/data; i_fill_valid decides the new valid bit
//   i_sel_fill, i_byte_sel  choose fill word or stored word, then the byte lane
//   o_sel_word, o_sel_byte  selected word and byte for the response registers
module flash_line_buffer
    import flash_read_pkg::*;
#(
    parameter int TAG_W = FLASH_ADDR_W
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [TAG_W-1:0]        i_lookup_tag,
    output logic                    o_hit,
    input  logic                    i_inval,
    input  logic                    i_fill_en,
    input  logic [TAG_W-1:0]        i_fill_tag,
    input  logic [FLASH_WORD_W-1:0] i_fill_word,
    input  logic                    i_fill_valid,
    input  logic                    i_sel_fill,
    input  logic                    i_byte_sel,
    output logic [FLASH_WORD_W-1:0] o_sel_word,
    output logic [7:0]              o_sel_byte
);

    logic                    r_valid;
    logic [TAG_W-1:0]        r_tag;
    logic [FLASH_WORD_W-1:0] r_data;
    logic [FLASH_WORD_W-1:0] w_word;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_fill_en) begin
            r_tag   <= i_fill_tag;
            r_data  <= i_fill_word;
            r_valid <= i_fill_valid;
        end else if (i_inval) begin
            r_valid <= 1'b0;
        end
    end

    assign o_hit      = r_valid && (r_tag == i_lookup_tag);
    assign w_word     = i_sel_fill ? i_fill_word : r_data;
    assign o_sel_word = w_word;
    assign o_sel_byte = sel_byte(w_word, i_byte_sel);

endmodule

// File: rtl/flash_read_ctrl.sv
// Timed byte-read front-end for an asynchronous NOR flash with a one-word
// line buffer. Misses drive the flash for WAIT_CYCLES wait states plus one
// capture cycle; hits are answered from the buffer one cycle after accept.
// Ports:
//   I_CLK, I_RESET                      clock, asynchronous active-high reset
//   I_REQ_VALID, I_REQ_ADDR, O_REQ_READY byte-read request handshake
//   I_FLUSH                              invalidate the line buffer
//   O_RESP_VALID/DATA/WORD, O_HIT        response (valid pulses, rest hold)
//   O_MISS_COUNT                         saturating count of flash accesses
//   I_FLASH_DATA, O_FLASH_*, O_ADDR_VALID_L  flash pins
//
// state      | meaning
// ST_IDLE    | ready for a request; flash deselected
// ST_WAIT    | address driven, CE/OE low, counting wait states
// ST_CAPTURE | last access cycle; flash data registered at its end
module flash_read_ctrl
    import flash_read_pkg::*;
#(
    parameter int WAIT_CYCLES = 4,
    parameter int ADDR_W      = 25
) (
    input  logic                    I_CLK,
    input  logic                    I_RESET,
    input  logic                    I_REQ_VALID,
    input  logic [ADDR_W-1:0]       I_REQ_ADDR,
    output logic                    O_REQ_READY,
    input  logic                    I_FLUSH,
    output logic                    O_RESP_VALID,
    output logic [7:0]              O_RESP_DATA,
    output logic [FLASH_WORD_W-1:0] O_RESP_WORD,
    output logic                    O_HIT,
    output logic [MISS_CNT_W-1:0]   O_MISS_COUNT,
    input  logic [FLASH_WORD_W-1:0] I_FLASH_DATA,
    output logic [ADDR_W-2:0]       O_FLASH_ADDR,
    output logic                    O_FLASH_CE_L,
    output logic                    O_FLASH_OE_L,
    output logic                    O_FLASH_WE_L,
    output logic                    O_ADDR_VALID_L,
    output logic                    O_FLASH_CLK
);

    localparam int WA_W = ADDR_W - 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic [WA_W-1:0]         r_flash_addr;
    logic                    r_byte_sel;
    logic                    r_flush_pend;
    logic                    r_resp_valid;
    logic [7:0]              r_resp_data;
    logic [FLASH_WORD_W-1:0] r_resp_word;
    logic                    r_hit;
    logic [MISS_CNT_W-1:0]   r_miss_count;

    logic                    w_idle;
    logic                    w_capture;
    logic                    w_accept;
    logic                    w_buf_hit;
    logic                    w_hit_acc;
    logic                    w_miss_acc;
    logic                    w_inval;
    logic                    w_fill_valid;
    logic                    w_byte_sel;
    logic [FLASH_WORD_W-1:0] w_sel_word;
    logic [7:0]              w_sel_byte;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_capture  = (r_state == ST_CAPTURE);
    assign w_accept   = I_REQ_VALID && w_idle;
    assign w_hit_acc  = w_accept && w_buf_hit;
    assign w_miss_acc = w_accept && !w_buf_hit;
    assign w_inval    = I_FLUSH && w_idle;
    // A flush seen at any point during the access keeps the new fill invalid.
    assign w_fill_valid = !(r_flush_pend || I_FLUSH);
    assign w_byte_sel   = w_capture ? r_byte_sel : I_REQ_ADDR[0];

    flash_line_buffer #(
        .TAG_W (WA_W)
    ) u_line_buffer (
        .i_clk        (I_CLK),
        .i_reset      (I_RESET),
        .i_lookup_tag (I_REQ_ADDR[ADDR_W-1:1]),
        .o_hit        (w_buf_hit),
        .i_inval      (w_inval),
        .i_fill_en    (w_capture),
        .i_fill_tag   (r_flash_addr),
        .i_fill_word  (I_FLASH_DATA),
        .i_fill_valid (w_fill_valid),
        .i_sel_fill   (w_capture),
        .i_byte_sel   (w_byte_sel),
        .o_sel_word   (w_sel_word),
        .o_sel_byte   (w_sel_byte)
    );

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_miss_acc) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_wait_cnt   <= '0;
            r_flash_addr <= '0;
            r_byte_sel   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_miss_count <= '0;
        end else begin
            if (w_miss_acc) begin
                r_flash_addr <= I_REQ_ADDR[ADDR_W-1:1];
                r_byte_sel   <= I_REQ_ADDR[0];
                r_wait_cnt   <= WAIT_LOAD;
                r_flush_pend <= 1'b0;
                if (r_miss_count != '1) begin
                    r_miss_count <= r_miss_count + 1'b1;
                end
            end else begin
                if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
                    r_wait_cnt <= r_wait_cnt - 1'b1;
                end
                if (!w_idle && I_FLUSH) begin
                    r_flush_pend <= 1'b1;
                end
            end
        end
    end

    // Response registers: data/word/hit hold between responses, valid pulses.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_word  <= '0;
            r_hit        <= 1'b0;
        end else if (w_hit_acc || w_capture) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_sel_byte;
            r_resp_word  <= w_sel_word;
            r_hit        <= !w_capture;
        end else begin
            r_resp_valid <= 1'b0;
        end
    end

    assign O_REQ_READY    = w_idle;
    assign O_RESP_VALID   = r_resp_valid;
    assign O_RESP_DATA    = r_resp_data;
    assign O_RESP_WORD    = r_resp_word;
    assign O_HIT          = r_hit;
    assign O_MISS_COUNT   = r_miss_count;
    assign O_FLASH_ADDR   = r_flash_addr;
    assign O_FLASH_CE_L   = w_idle;
    assign O_FLASH_OE_L   = w_idle;
    assign O_ADDR_VALID_L = w_idle;
    assign O_FLASH_WE_L   = 1'b1;
    assign O_FLASH_CLK    = 1'b1;

endmodule

// File: tb/tb_flash_read_ctrl.sv
module tb_flash_read_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [24:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [15:0] resp_word;
    logic        hit;
    logic [15:0] miss_count;
    logic [15:0] flash_data;
    logic [23:0] flash_addr;
    logic        ce_l, oe_l, we_l, av_l, fclk;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Flash content: one marked word, everything else derived from the address.
    function automatic logic [15:0] mem(input logic [23:0] w);
        return (w == 24'h000100) ? 16'hA55A : {w[7:0], ~w[7:0]};
    endfunction

    assign flash_data = mem(flash_addr);

    flash_read_ctrl #(.WAIT_CYCLES(4), .ADDR_W(25)) dut (
        .I_CLK          (clk),
        .I_RESET        (rst),
        .I_REQ_VALID    (req_valid),
        .I_REQ_ADDR     (req_addr),
        .O_REQ_READY    (req_ready),
        .I_FLUSH        (flush),
        .O_RESP_VALID   (resp_valid),
        .O_RESP_DATA    (resp_data),
        .O_RESP_WORD    (resp_word),
        .O_HIT          (hit),
        .O_MISS_COUNT   (miss_count),
        .I_FLASH_DATA   (flash_data),
        .O_FLASH_ADDR   (flash_addr),
        .O_FLASH_CE_L   (ce_l),
        .O_FLASH_OE_L   (oe_l),
        .O_FLASH_WE_L   (we_l),
        .O_ADDR_VALID_L (av_l),
        .O_FLASH_CLK    (fclk)
    );

    typedef struct {
        logic [24:0] addr;
        int          flush_at;   // -1 none, 0 with request, k = k-th negedge after accept
        logic        exp_hit;
        logic [7:0]  exp_data;
        logic [15:0] exp_word;
        logic [15:0] exp_mc;
        int          exp_lat;
        int          exp_ce;
    } vec_t;

    function automatic vec_t mk(input logic [24:0] a, input int fa, input logic h,
                                input logic [7:0] d, input logic [15:0] w,
                                input logic [15:0] mc);
        vec_t v;
        v.addr = a; v.flush_at = fa; v.exp_hit = h; v.exp_data = d;
        v.exp_word = w; v.exp_mc = mc;
        v.exp_lat = h ? 1 : 6;
        v.exp_ce  = h ? 0 : 5;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        int lat, ce_cnt, rdy_lo;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = v.addr;
        flush     = (v.flush_at == 0);
        #1;
        chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0; ce_cnt = 0; rdy_lo = 0;
        for (int i = 1; i <= 30; i++) begin
            flush = (i == v.flush_at);
            if (!ce_l) ce_cnt++;
            if (!req_ready) rdy_lo++;
            if (resp_valid) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        chk({tag, " latency"},  lat,                      v.exp_lat);
        chk({tag, " ce_low"},   ce_cnt,                   v.exp_ce);
        chk({tag, " rdy_low"},  rdy_lo,                   v.exp_ce);
        chk({tag, " hit"},      {31'd0, hit},             {31'd0, v.exp_hit});
        chk({tag, " data"},     {24'd0, resp_data},       {24'd0, v.exp_data});
        chk({tag, " word"},     {16'd0, resp_word},       {16'd0, v.exp_word});
        chk({tag, " misscnt"},  {16'd0, miss_count},      {16'd0, v.exp_mc});
    endtask

    vec_t tbl[14];
    vec_t sat[3];

    initial begin
        tbl[0]  = mk(25'h000000, -1, 1'b0, 8'hFF, 16'h00FF, 16'd1);
        tbl[1]  = mk(25'h000200, -1, 1'b0, 8'h5A, 16'hA55A, 16'd2);
        tbl[2]  = mk(25'h000201,  1, 1'b1, 8'hA5, 16'hA55A, 16'd2);
        tbl[3]  = mk(25'h000200, -1, 1'b0, 8'h5A, 16'hA55A, 16'd3);
        tbl[4]  = mk(25'h000300,  2, 1'b0, 8'h7F, 16'h807F, 16'd4);
        tbl[5]  = mk(25'h000301, -1, 1'b0, 8'h80, 16'h807F, 16'd5);
        tbl[6]  = mk(25'h000301,  0, 1'b1, 8'h80, 16'h807F, 16'd5);
        tbl[7]  = mk(25'h000300, -1, 1'b0, 8'h7F, 16'h807F, 16'd6);
        tbl[8]  = mk(25'h000401, -1, 1'b0, 8'h00, 16'h00FF, 16'd7);
        tbl[9]  = mk(25'h000400, -1, 1'b1, 8'hFF, 16'h00FF, 16'd7);
        tbl[10] = mk(25'h000201, -1, 1'b0, 8'hA5, 16'hA55A, 16'd8);
        tbl[11] = mk(25'h000500,  5, 1'b0, 8'h7F, 16'h807F, 16'd9);
        tbl[12] = mk(25'h000500, -1, 1'b0, 8'h7F, 16'h807F, 16'd10);
        tbl[13] = mk(25'h000501, -1, 1'b1, 8'h80, 16'h807F, 16'd10);
        sat[0]  = mk(25'h000A00, -1, 1'b0, 8'hFF, 16'h00FF, 16'hFFFE);
        sat[1]  = mk(25'h000C00, -1, 1'b0, 8'hFF, 16'h00FF, 16'hFFFF);
        sat[2]  = mk(25'h000A00, -1, 1'b0, 8'hFF, 16'h00FF, 16'hFFFF);

        // Reset state
        #12;
        n_vec++;
        chk("rst ready",   {31'd0, req_ready},  32'd1);
        chk("rst ce_l",    {31'd0, ce_l},       32'd1);
        chk("rst oe_l",    {31'd0, oe_l},       32'd1);
        chk("rst av_l",    {31'd0, av_l},       32'd1);
        chk("rst addr",    {8'd0, flash_addr},  32'd0);
        chk("rst rvalid",  {31'd0, resp_valid}, 32'd0);
        chk("rst misscnt", {16'd0, miss_count}, 32'd0);
        chk("rst word",    {16'd0, resp_word},  32'd0);
        chk("we_l/fclk",   {30'd0, we_l, fclk}, 32'd3);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) apply_vec(i, tbl[i]);

        // Response fields hold after the valid pulse
        @(negedge clk);
        n_vec++;
        chk("hold rvalid", {31'd0, resp_valid}, 32'd0);
        chk("hold data",   {24'd0, resp_data},  32'h80);
        chk("hold hit",    {31'd0, hit},        32'd1);

        // Reset two cycles into WAIT aborts the access without a clock edge
        req_valid = 1'b1;
        req_addr  = 25'h000600;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        chk("abort ce_l",    {31'd0, ce_l},       32'd1);
        chk("abort addr",    {8'd0, flash_addr},  32'd0);
        chk("abort misscnt", {16'd0, miss_count}, 32'd0);
        chk("abort rvalid",  {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (resp_valid) seen++;
            end
            chk("abort no_resp", seen, 0);
        end
        chk("abort ready", {31'd0, req_ready}, 32'd1);

        // Saturation of the miss counter from a preloaded near-full value
        @(negedge clk);
        dut.r_miss_count = 16'hFFFD;
        for (int i = 0; i < 3; i++) apply_vec(20 + i, sat[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
